tmp125_spi_reader: RTL and testbench

SPI master that reads the TMP125 temperature sensor (or the thermometer_model emulator in simulation) on behalf of the thermostat controller. Generates SCK/CS_n from the system clock, shifts in one 16-bit frame MSB first, and presents the 10-bit two's-complement temperature (0.25 °C/LSB) with a one-cycle valid strobe. Triggered by request or by an optional internal periodic timer.

---
 rtl/tmp125_spi_reader_pkg.sv | 25 ++
 rtl/tmp125_sclk_gen.sv | 45 ++++
 rtl/tmp125_spi_reader.sv | 118 +++++++++++
 tb/tb_tmp125_spi_reader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmp125_spi_reader_pkg.sv
// Shared frame layout, FSM state encoding and timing helpers for the TMP125 SPI reader.
package tmp125_spi_reader_pkg;

  localparam int unsigned TMP125_FRAME_W  = 16;
  localparam int unsigned TMP125_TEMP_MSB = 14;
  localparam int unsigned TMP125_TEMP_LSB = 5;
  localparam int unsigned TMP125_ERR_BIT  = 15;
  localparam int unsigned TMP125_TEMP_W   = TMP125_TEMP_MSB - TMP125_TEMP_LSB + 1;
  // Only frame bits [15:5] are captured; the trailing bits carry nothing we use.
  localparam int unsigned TMP125_CAP_W    = TMP125_ERR_BIT - TMP125_TEMP_LSB + 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGuard
  } state_e;

  function automatic int unsigned half_period(input int unsigned clk_freq,
                                              input int unsigned spi_freq);
    return clk_freq / (2 * spi_freq);
  endfunction

endpackage

// File: rtl/tmp125_sclk_gen.sv
// SCK generator: half-period counter with rise/fall strobes; SCK is held high when disabled.
module tmp125_sclk_gen
  import tmp125_spi_reader_pkg::*;
#(
  parameter int unsigned g_half = 50
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_en_next,
  output logic o_rise,
  output logic o_fall,
  output logic o_spi_clk
);

  localparam int unsigned CntW = $clog2(g_half + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_phase;
  logic            r_sclk;
  logic            w_wrap;
  logic            w_phase_next;

  assign w_wrap       = i_en && (r_cnt == CntW'(g_half - 1));
  assign o_rise       = w_wrap && !r_phase;
  assign o_fall       = w_wrap && r_phase;
  assign w_phase_next = i_en ? (r_phase ^ w_wrap) : 1'b0;

  // SCK is registered from next-cycle values so it lines up with the FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_sclk  <= 1'b1;
    end else begin
      r_phase <= w_phase_next;
      r_sclk  <= !i_en_next || w_phase_next;
      if (!i_en || w_wrap) r_cnt <= '0;
      else                 r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_spi_clk = r_sclk;

endmodule

// File: rtl/tmp125_spi_reader.sv
// SPI master reading one 16-bit TMP125 frame per trigger and presenting the 10-bit temperature.
module tmp125_spi_reader
  import tmp125_spi_reader_pkg::*;
#(
  parameter int unsigned g_clk_freq     = 1000000,
  parameter int unsigned g_spi_clk_freq = 10000,
  parameter int unsigned g_auto_period  = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_spi_clk,
  output logic                     o_spi_cs_n,
  input  logic                     i_spi_so,
  output logic [TMP125_TEMP_W-1:0] o_temp,
  output logic                     o_temp_valid,
  output logic                     o_frame_err
);

  localparam int unsigned H     = half_period(g_clk_freq, g_spi_clk_freq);
  localparam int unsigned HCntW = $clog2(H + 1);
  localparam int unsigned AutoW = (g_auto_period > 0) ? $clog2(g_auto_period + 1) : 1;

  if (H < 2) begin : g_bad_half
    $error("tmp125_spi_reader: SCK half period must be at least 2 system clocks");
  end

  state_e                   r_state, w_state_next;
  logic [HCntW-1:0]         r_hcnt;
  logic [3:0]               r_bitcnt;
  logic [TMP125_CAP_W-1:0]  r_shift;
  logic                     r_so_meta, r_so_sync;
  logic [TMP125_TEMP_W-1:0] r_temp;
  logic                     r_err, r_valid, r_busy, r_cs_n;
  logic                     w_hcnt_done, w_rise, w_fall, w_auto_trig;

  if (g_auto_period > 0) begin : g_auto
    logic [AutoW-1:0] r_auto;
    assign w_auto_trig = (r_auto == AutoW'(g_auto_period - 1));
    always_ff @(posedge i_clk) begin
      if (i_rst || w_auto_trig) r_auto <= '0;
      else                      r_auto <= r_auto + 1'b1;
    end
  end else begin : g_no_auto
    assign w_auto_trig = 1'b0;
  end

  tmp125_sclk_gen #(
    .g_half(H)
  ) u_sclk_gen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (r_state == StShift),
    .i_en_next (w_state_next == StShift),
    .o_rise    (w_rise),
    .o_fall    (w_fall),
    .o_spi_clk (o_spi_clk)
  );

  assign w_hcnt_done = (r_hcnt == HCntW'(H - 1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start || w_auto_trig) w_state_next = StSetup;
      StSetup: if (w_hcnt_done) w_state_next = StShift;
      StShift: if (w_fall && r_bitcnt == 4'(TMP125_FRAME_W - 1)) w_state_next = StHold;
      StHold:  if (w_hcnt_done) w_state_next = StGuard;
      StGuard: if (w_hcnt_done) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_hcnt    <= '0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_so_meta <= 1'b0;
      r_so_sync <= 1'b0;
      r_temp    <= '0;
      r_err     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_cs_n    <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_so_meta <= i_spi_so;
      r_so_sync <= r_so_meta;
      r_busy    <= (w_state_next != StIdle);
      r_cs_n    <= !(w_state_next inside {StSetup, StShift, StHold});
      r_valid   <= (r_state == StHold) && w_hcnt_done;

      if ((r_state inside {StSetup, StHold, StGuard}) && !w_hcnt_done) r_hcnt <= r_hcnt + 1'b1;
      else                                                            r_hcnt <= '0;

      if (r_state != StShift) r_bitcnt <= '0;
      else if (w_fall)        r_bitcnt <= r_bitcnt + 1'b1;

      // Stop capturing once bits [15:5] are in so they stay aligned at the LSB end.
      if (w_rise && r_bitcnt < 4'(TMP125_CAP_W)) r_shift <= {r_shift[TMP125_CAP_W-2:0], r_so_sync};

      if (r_state == StHold && w_hcnt_done) begin
        r_temp <= r_shift[TMP125_TEMP_W-1:0];
        r_err  <= r_shift[TMP125_CAP_W-1];
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_spi_cs_n   = r_cs_n;
  assign o_temp       = r_temp;
  assign o_temp_valid = r_valid;
  assign o_frame_err  = r_err;

endmodule

// File: tb/tb_tmp125_spi_reader.sv
// Bench for tmp125_spi_reader: a request-driven DUT and an auto-mode DUT, each against a frame model.
module tb_tmp125_spi_reader;

  localparam int H     = 50;
  localparam int AutoP = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, rst1 = 1'b1, start0 = 1'b0, start1 = 1'b0;
  logic        so0 = 1'b0, so1 = 1'b0;
  logic [1:0]  busy, sck, cs_n, valid, ferr;
  logic [9:0]  temp [2];
  logic [15:0] slv_word [2];

  int cyc = 0;
  int checks = 0, failures = 0;

  always @(posedge clk) cyc++;

  tmp125_spi_reader #(
    .g_clk_freq(1000000), .g_spi_clk_freq(10000), .g_auto_period(0)
  ) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_start(start0), .o_busy(busy[0]), .o_spi_clk(sck[0]),
    .o_spi_cs_n(cs_n[0]), .i_spi_so(so0), .o_temp(temp[0]), .o_temp_valid(valid[0]),
    .o_frame_err(ferr[0])
  );

  tmp125_spi_reader #(
    .g_clk_freq(1000000), .g_spi_clk_freq(10000), .g_auto_period(AutoP)
  ) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_start(start1), .o_busy(busy[1]), .o_spi_clk(sck[1]),
    .o_spi_cs_n(cs_n[1]), .i_spi_so(so1), .o_temp(temp[1]), .o_temp_valid(valid[1]),
    .o_frame_err(ferr[1])
  );

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cycle=%0d actual=%0h expected=%0h", name, i, cyc, act, exp);
    end
  endtask

  // Sensor slaves: MSB presented when CS falls, each later bit after an SCK fall.
  logic [15:0] lw0, lw1;
  int nf0, nf1;
  always @(negedge cs_n[0] or negedge sck[0]) begin
    if (sck[0]) begin lw0 = slv_word[0]; nf0 = 0; so0 = lw0[15]; end
    else if (!cs_n[0]) begin if (nf0 < 16) so0 = lw0[15-nf0]; nf0++; end
  end
  always @(negedge cs_n[1] or negedge sck[1]) begin
    if (sck[1]) begin lw1 = slv_word[1]; nf1 = 0; so1 = lw1[15]; end
    else if (!cs_n[1]) begin if (nf1 < 16) so1 = lw1[15-nf1]; nf1++; end
  end

  // Event monitors.
  int rises0 = 0, vcnt0 = 0, vcyc0 = -1, csf0 = -1, csr0 = -1, gap0 = -1, bfall0 = -1;
  int vcnt1 = 0;
  int cs_falls1 [$];
  always @(posedge sck[0]) rises0++;
  always @(posedge cs_n[0]) csr0 = cyc;
  always @(negedge cs_n[0]) begin if (csr0 >= 0) gap0 = cyc - csr0; csf0 = cyc; end
  always @(negedge busy[0]) bfall0 = cyc;
  always @(negedge cs_n[1]) cs_falls1.push_back(cyc);
  always @(negedge clk) begin
    if (valid[0] === 1'b1) begin vcnt0++; vcyc0 = cyc; end
    if (valid[1] === 1'b1) vcnt1++;
  end

  // Frame model: k counts cycles since the trigger cycle; -1 means idle.
  int          mk [2] = '{-1, -1};
  int          mauto [2] = '{0, 0};
  logic [9:0]  mtemp [2] = '{10'd0, 10'd0};
  logic        merr [2] = '{1'b0, 1'b0};
  logic [15:0] mword [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   k;
      logic r, s, fire, e_busy, e_cs_n, e_sck, e_valid;
      r = (i == 0) ? rst0 : rst1;
      s = (i == 0) ? start0 : start1;
      k = mk[i];
      e_busy  = (k >= 1);
      e_cs_n  = !(k >= 1 && k <= 34 * H);
      e_sck   = !(k >= 1 + H && k <= 33 * H && ((k - 1 - H) % (2 * H)) < H);
      e_valid = (k == 1 + 34 * H);
      chk("busy", i, 32'(busy[i]), 32'(e_busy));
      chk("cs_n", i, 32'(cs_n[i]), 32'(e_cs_n));
      chk("sck", i, 32'(sck[i]), 32'(e_sck));
      chk("temp_valid", i, 32'(valid[i]), 32'(e_valid));
      chk("temp", i, 32'(temp[i]), 32'(mtemp[i]));
      chk("frame_err", i, 32'(ferr[i]), 32'(merr[i]));
      fire = (i == 1) && (mauto[i] == AutoP - 1);
      if (r) begin
        mk[i] = -1; mauto[i] = 0; mtemp[i] = '0; merr[i] = 1'b0;
      end else begin
        if (i == 1) mauto[i] = fire ? 0 : mauto[i] + 1;
        if (mk[i] < 0) begin
          if (s || fire) begin mk[i] = 1; mword[i] = slv_word[i]; end
        end else begin
          mk[i]++;
          if (mk[i] > 35 * H) mk[i] = -1;
          else if (mk[i] == 1 + 34 * H) begin
            mtemp[i] = mword[i][14:5];
            merr[i]  = mword[i][15];
          end
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic frame0(input logic [15:0] w, input logic [9:0] et, input logic ee,
                        input string tag);
    int t0, r0, v0;
    slv_word[0] = w;
    r0 = rises0; v0 = vcnt0; t0 = cyc;
    start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (1800) @(posedge clk);
    #1;
    chk({tag, "_cs_fall"}, 0, csf0, t0 + 1);
    chk({tag, "_sck_rises"}, 0, rises0 - r0, 16);
    chk({tag, "_valid_count"}, 0, vcnt0 - v0, 1);
    chk({tag, "_valid_cycle"}, 0, vcyc0, t0 + 1701);
    chk({tag, "_busy_fall"}, 0, bfall0, t0 + 1751);
    chk({tag, "_temp"}, 0, 32'(temp[0]), 32'(et));
    chk({tag, "_frame_err"}, 0, 32'(ferr[0]), 32'(ee));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    slv_word[0] = '0;
    slv_word[1] = 16'h0C80;
    fork
      begin : dut0_seq
        int r0, v0, t0;
        repeat (3) @(posedge clk);
        #1 rst0 = 1'b0;
        r0 = rises0;
        repeat (1000) @(posedge clk);
        #1;
        chk("idle_sck_rises", 0, rises0 - r0, 0);
        chk("idle_sck", 0, 32'(sck[0]), 1);
        chk("idle_cs_n", 0, 32'(cs_n[0]), 1);
        chk("idle_busy", 0, 32'(busy[0]), 0);
        chk("idle_temp", 0, 32'(temp[0]), 0);
        chk("idle_valid_count", 0, vcnt0, 0);

        frame0(16'h0C80, 10'h064, 1'b0, "plus25");
        frame0(16'h7FE0, 10'h3FF, 1'b0, "minus_quarter");
        frame0(16'hFC80, 10'h3E4, 1'b1, "minus7_err");

        // Level start: frames follow each other after guard plus the idle trigger cycle.
        slv_word[0] = 16'h1900;
        v0 = vcnt0; t0 = cyc; start0 = 1'b1;
        repeat (3600) @(posedge clk);
        #1 start0 = 1'b0;
        repeat (1900) @(posedge clk);
        #1;
        chk("b2b_frames", 0, vcnt0 - v0, 3);
        chk("b2b_cs_high_gap", 0, gap0, H + 1);
        chk("b2b_third_cs_fall", 0, csf0, t0 + 2 * (35 * H + 1) + 1);
        chk("b2b_temp", 0, 32'(temp[0]), 32'h0C8);

        slv_word[0] = 16'h0C80;
        v0 = vcnt0; t0 = cyc; start0 = 1'b1;
        for (int c = 1; c < 1900; c++) begin
          @(posedge clk); #1;
          start0 = (c == 300 || c == 800 || c == 1200 || c == 1650);
        end
        start0 = 1'b0;
        chk("ignored_valid_count", 0, vcnt0 - v0, 1);
        chk("ignored_busy_fall", 0, bfall0, t0 + 1751);
        chk("ignored_temp", 0, 32'(temp[0]), 32'h064);

        slv_word[0] = 16'h3200;
        r0 = rises0; v0 = vcnt0; start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        for (int c = 0; c < 2000 && (rises0 - r0) < 7; c++) begin @(posedge clk); #1; end
        chk("rst_at_rise7", 0, rises0 - r0, 7);
        rst0 = 1'b1;
        @(posedge clk); #1 rst0 = 1'b0;
        chk("rst_cs_n", 0, 32'(cs_n[0]), 1);
        chk("rst_sck", 0, 32'(sck[0]), 1);
        chk("rst_busy", 0, 32'(busy[0]), 0);
        chk("rst_temp", 0, 32'(temp[0]), 0);
        repeat (2000) @(posedge clk);
        #1;
        chk("rst_no_valid", 0, vcnt0 - v0, 0);
        frame0(16'h1900, 10'h0C8, 1'b0, "after_rst");
      end
      begin : dut1_seq
        int n;
        repeat (3) @(posedge clk);
        #1 rst1 = 1'b0;
        n = cyc;
        wait_until(n + 2500);  slv_word[1] = 16'h7FE0;
        wait_until(n + 7000);
        chk("auto_temp_1", 1, 32'(temp[1]), 32'h3FF);
        wait_until(n + 7500);  slv_word[1] = 16'h3200;
        wait_until(n + 9999);  start1 = 1'b1;
        wait_until(n + 10000); start1 = 1'b0;
        wait_until(n + 12000);
        chk("auto_temp_2", 1, 32'(temp[1]), 32'h190);
        wait_until(n + 12500); slv_word[1] = 16'hFC80;
        wait_until(n + 21800);
        chk("auto_frame_count", 1, cs_falls1.size(), 4);
        chk("auto_valid_count", 1, vcnt1, 4);
        for (int j = 0; j < cs_falls1.size() && j < 4; j++)
          chk("auto_frame_start", 1, cs_falls1[j], n + AutoP * (j + 1));
        chk("auto_temp_3", 1, 32'(temp[1]), 32'h3E4);
        chk("auto_frame_err", 1, 32'(ferr[1]), 1);
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
